// File: rtl/mul_issue.sv
// Issue scheduler for the mul/div/bit-manipulation unit: age-ordered compacting
// queue with operand wakeup, commit-register kill and a single-divider guard.
module mul_issue #(
  parameter int unsigned NQ         = 4,
  parameter int unsigned CNTRL_SIZE = 7,
  parameter int unsigned NCOMMIT    = 32,
  parameter int unsigned LNCOMMIT   = 5,
  parameter int unsigned NHART      = 1,
  parameter int unsigned LNHART     = 0,
  parameter int unsigned RA         = 5,
  localparam int unsigned HW        = (NHART == 1) ? 1 : LNHART
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNTRL_SIZE-1:0] in_control,
  input  logic [LNCOMMIT-1:0]   in_rd,
  input  logic                  in_makes_rd,
  input  logic [HW-1:0]         in_hart,
  input  logic [RA:0]           in_rs1,
  input  logic [RA:0]           in_rs2,
  input  logic                  in_rs1_pend,
  input  logic                  in_rs2_pend,
  input  logic [LNCOMMIT-1:0]   in_rs1_tag,
  input  logic [LNCOMMIT-1:0]   in_rs2_tag,
  input  logic [NCOMMIT-1:0]    wake,
  input  logic [NCOMMIT-1:0]    commit_kill_0,
  input  logic                  divide_busy,
  output logic                  enable,
  output logic [CNTRL_SIZE-1:0] control,
  output logic [LNCOMMIT-1:0]   rd,
  output logic                  makes_rd,
  output logic [HW-1:0]         hart,
  output logic [RA:0]           rf_rs1,
  output logic [RA:0]           rf_rs2,
  output logic                  empty
);

  localparam int unsigned CW = $clog2(NQ + 1);
  localparam int unsigned LQ = $clog2(NQ);

  typedef struct packed {
    logic                  valid;
    logic [CNTRL_SIZE-1:0] control;
    logic [LNCOMMIT-1:0]   rd;
    logic                  makes_rd;
    logic [HW-1:0]         hart;
    logic [RA:0]           rs1;
    logic [RA:0]           rs2;
    logic                  pend1;
    logic [LNCOMMIT-1:0]   tag1;
    logic                  pend2;
    logic [LNCOMMIT-1:0]   tag2;
  } entry_t;

  entry_t                r_q   [NQ];
  entry_t                w_q_d [NQ];
  logic                  r_enable;
  logic [CNTRL_SIZE-1:0] r_control;
  logic [LNCOMMIT-1:0]   r_rd;
  logic                  r_makes_rd;
  logic [HW-1:0]         r_hart;
  logic [RA:0]           r_rf_rs1;
  logic [RA:0]           r_rf_rs2;

  logic [CW-1:0] w_count;
  logic          w_div_ok;
  logic          w_sel_valid;
  logic [LQ-1:0] w_sel;
  logic          w_issue;

  // bit0 or bit5 of the control field marks the mul class; everything else uses the divider
  function automatic logic f_is_mul(input logic [CNTRL_SIZE-1:0] c);
    return c[0] | c[5];
  endfunction

  // Occupancy and oldest-eligible selection from registered state only
  always_comb begin
    w_count     = '0;
    w_sel_valid = 1'b0;
    w_sel       = '0;
    // A div just issued has not yet raised divide_busy, so guard it here
    w_div_ok    = !divide_busy && !(r_enable && !f_is_mul(r_control));
    for (int i = NQ - 1; i >= 0; i--) begin
      w_count = w_count + CW'(r_q[i].valid);
      if (r_q[i].valid && !r_q[i].pend1 && !r_q[i].pend2 &&
          (f_is_mul(r_q[i].control) || w_div_ok)) begin
        w_sel_valid = 1'b1;
        w_sel       = LQ'(i);
      end
    end
    w_issue = w_sel_valid && !commit_kill_0[r_q[w_sel].rd];
  end

  assign in_ready = (w_count < CW'(NQ));
  assign empty    = (w_count == '0);

  // Next queue: survivors compacted in age order, then the new entry appended
  always_comb begin
    logic          w_keep;
    logic [CW-1:0] w_pos;
    w_keep = 1'b0;
    w_pos  = '0;
    for (int j = 0; j < NQ; j++) begin
      w_q_d[j] = '0;
    end
    for (int i = 0; i < NQ; i++) begin
      w_keep = r_q[i].valid && !commit_kill_0[r_q[i].rd] &&
               !(w_sel_valid && (w_sel == LQ'(i)));
      if (w_keep) begin
        for (int j = 0; j < NQ; j++) begin
          if (w_pos == CW'(j)) begin
            w_q_d[j]       = r_q[i];
            w_q_d[j].pend1 = r_q[i].pend1 && !wake[r_q[i].tag1];
            w_q_d[j].pend2 = r_q[i].pend2 && !wake[r_q[i].tag2];
          end
        end
        w_pos = w_pos + CW'(1);
      end
    end
    if (in_valid && in_ready && !commit_kill_0[in_rd]) begin
      for (int j = 0; j < NQ; j++) begin
        if (w_pos == CW'(j)) begin
          w_q_d[j].valid    = 1'b1;
          w_q_d[j].control  = in_control;
          w_q_d[j].rd       = in_rd;
          w_q_d[j].makes_rd = in_makes_rd;
          w_q_d[j].hart     = in_hart;
          w_q_d[j].rs1      = in_rs1;
          w_q_d[j].rs2      = in_rs2;
          w_q_d[j].pend1    = in_rs1_pend && !wake[in_rs1_tag];
          w_q_d[j].tag1     = in_rs1_tag;
          w_q_d[j].pend2    = in_rs2_pend && !wake[in_rs2_tag];
          w_q_d[j].tag2     = in_rs2_tag;
        end
      end
    end
  end

  // Queue and issue output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NQ; i++) begin
        r_q[i] <= '0;
      end
      r_enable   <= 1'b0;
      r_control  <= '0;
      r_rd       <= '0;
      r_makes_rd <= 1'b0;
      r_hart     <= '0;
      r_rf_rs1   <= '0;
      r_rf_rs2   <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        r_q[i] <= w_q_d[i];
      end
      r_enable <= w_issue;
      if (w_issue) begin
        r_control  <= r_q[w_sel].control;
        r_rd       <= r_q[w_sel].rd;
        r_makes_rd <= r_q[w_sel].makes_rd;
        r_hart     <= r_q[w_sel].hart;
        r_rf_rs1   <= r_q[w_sel].rs1;
        r_rf_rs2   <= r_q[w_sel].rs2;
      end
    end
  end

  assign enable   = r_enable;
  assign control  = r_control;
  assign rd       = r_rd;
  assign makes_rd = r_makes_rd;
  assign hart     = r_hart;
  assign rf_rs1   = r_rf_rs1;
  assign rf_rs2   = r_rf_rs2;

endmodule

// File: doc/mul_issue.md
# mul_issue

Issue scheduler for the multiply/divide/bit-manipulation unit. Holds up to NQ dispatched mul-class and div-class operations in an age-ordered queue and tracks operand readiness through commit-register wakeups. It drives the unit's `enable`/`control`/`rd`/`makes_rd`/`hart` inputs and the register-file read addresses. It obeys the unit's single non-pipelined divider through `divide_busy`, and drops operations whose destination commit register is killed.

## Interface
- NQ, 4, queue depth (2..8)
- CNTRL_SIZE, 7, width of the control field passed to the unit
- NCOMMIT, 32, number of commit registers
- LNCOMMIT, 5, bits to encode a commit register
- NHART, 1, number of harts
- LNHART, 0, bits to encode a hart
- RA, 5, architectural register index width; source addresses are RA+1 bits (commit-or-architectural)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  dispatch offers an operation
- in_ready  out  1  queue accepts this cycle (count < NQ)
- in_control  in  CNTRL_SIZE  unit control encoding; bit0=1 or bit5=1 is mul-class, otherwise div-class
- in_rd  in  LNCOMMIT  destination commit register
- in_makes_rd  in  1  operation writes rd
- in_hart  in  (NHART==1?1:LNHART)  hart
- in_rs1, in_rs2  in  RA+1  source register-file addresses
- in_rs1_pend, in_rs2_pend  in  1  source awaits a commit-register wakeup
- in_rs1_tag, in_rs2_tag  in  LNCOMMIT  commit register awaited
- wake  in  NCOMMIT  one bit per commit register written back this cycle
- commit_kill_0  in  NCOMMIT  commit registers being flushed this cycle
- divide_busy  in  1  divider occupied (from unit)
- enable  out  1  issue strobe to unit
- control  out  CNTRL_SIZE, rd  out  LNCOMMIT, makes_rd  out  1, hart  out  hart width  issued op fields
- rf_rs1, rf_rs2  out  RA+1  register-file read addresses; data returns next cycle straight to unit r1/r2
- empty  out  1  no valid entries

## Operation
- Entry: valid, control, rd, makes_rd, hart, rs1, rs2, pend1, tag1, pend2, tag2. Entry 0 is oldest; queue is compacting.
- Enqueue: on in_valid && in_ready, append at first free slot after this cycle's removals. Drop silently if commit_kill_0[in_rd]. Clear pendN if wake[in_rsN_tag] is set in the same cycle.
- in_ready depends only on the registered count. When full, no accept even if an entry issues this cycle.
- Wakeup: any valid entry with pendN && wake[tagN] clears pendN at the next edge.
- Kill: any valid entry with commit_kill_0[rd] is invalidated at the next edge. Any number of entries may be killed at once, and compaction preserves the age order of survivors.
- Ready: valid && !pend1 && !pend2, using registered state only. An entry woken this cycle is selectable next cycle.
- Select: the oldest ready entry, subject to the div guard. A div-class entry is eligible only if !divide_busy && !(enable && current output op is div-class). Mul-class entries are always eligible. An ineligible div does not block a younger ready mul.
- A selected entry is removed, and the output register loads it at the next edge. If commit_kill_0[rd] hits the selected entry in the select cycle, it is removed without issue and enable stays 0.
- Output: enable, control, rd, makes_rd, hart, rf_rs1, rf_rs2 are registered. enable is high for exactly one cycle per issue. Fields are don't-care when enable=0. Kills arriving in the enable cycle are handled by the unit.

## Timing
- Reset: all entries invalid; enable=0, empty=1, in_ready=1; other outputs don't-care. Reset asserted mid-operation discards everything by the next edge, including a pending output, so enable=0 the cycle after reset.
- Latency with no pending operands:
  - accept at cycle T
  - selectable T+1
  - enable at T+2
  - operands at the unit at T+3 (register-file read latency 1)
- Mul throughput is 1 per cycle.
- Div spacing: the unit raises divide_busy two cycles after select. The self-guard covers the enable cycle, so no two divs are ever issued within the divider's busy window.
- wake at cycle W on a pending source allows enable no earlier than W+2.

## Test plan
- Reset, then accept mul (control=7'b0000001, rd=3, no pend) at T0 -> enable=1 at T2 with rd=3, rf_rs1/rf_rs2 as given; enable=0 at T3; empty=1 at T3.
- Enqueue div (rd=1) then div (rd=2) back-to-back, divide_busy modelled as unit does -> first div enables at T2. The second enables only after divide_busy falls, and never in the cycle after the first enable.
- Div blocked (divide_busy=1) with a younger ready mul rd=5 -> mul issues at the earliest slot; div remains queued and issues after divide_busy=0.
- Fill 4 entries with pend1 on tag 9 -> in_ready=0, no enable. Pulse wake[9] at W -> enable at W+2, then three further enables on consecutive cycles in age order; in_ready=1 once count<4.
- Queue rd=4,6,8 all pending; assert commit_kill_0 bits 4 and 8 for one cycle -> only rd=6 remains; after wake it issues; no enable ever carries rd 4 or 8.
- Entry selected at cycle S while commit_kill_0[rd] asserts at S -> enable=0 at S+1, and the entry is gone. Reset asserted the cycle after a select -> enable=0 and empty=1 after the reset edge.
